// File: rtl/data_mem_copier_pkg.sv
// data_mem_copier_pkg: shared widths and FSM encoding for the block-copy engine.
// Revision: 1.0
`default_nettype none

package data_mem_copier_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } copier_state_e;

endpackage : data_mem_copier_pkg

`default_nettype wire

// File: rtl/data_mem_copier.sv
// data_mem_copier: copies LENGTH words from a source to a destination base, one word per read/write pair.
// Revision: 1.0
`default_nettype none

module data_mem_copier
  import data_mem_copier_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_read,
  output logic              mem_write
);

  copier_state_e     state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [DATA_W-1:0] buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= length;
            idx_q   <= '0;
            state_q <= (length != '0) ? ST_READ : ST_DONE;
          end
        end
        ST_READ: begin
          buf_q   <= mem_read_data;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          // len_q is nonzero here, so len_q-1 cannot underflow.
          if (idx_q == len_q - LEN_W'(1)) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + LEN_W'(1);
            state_q <= ST_READ;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore decode; address sums wrap naturally at ADDR_W bits.
  always_comb begin
    busy           = (state_q != ST_IDLE);
    done           = (state_q == ST_DONE);
    mem_read       = (state_q == ST_READ);
    mem_write      = (state_q == ST_WRITE);
    mem_addr       = '0;
    mem_write_data = '0;
    if (state_q == ST_READ) begin
      mem_addr = src_q + ADDR_W'(idx_q);
    end else if (state_q == ST_WRITE) begin
      mem_addr       = dst_q + ADDR_W'(idx_q);
      mem_write_data = buf_q;
    end
  end

endmodule : data_mem_copier

`default_nettype wire

// File: tb/tb_data_mem_copier.sv
// tb_data_mem_copier: self-checking bench with a 64K-word data memory responder and a copy model.
// Revision: 1.0
`default_nettype none

module tb_data_mem_copier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        mem_read;
  logic        mem_write;

  always #5 clk = ~clk;

  data_mem_copier dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write)
  );

  // Data memory responder with a backdoor write port for preloading.
  logic [15:0] mem  [0:65535];
  logic [15:0] refm [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [15:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_write) mem[mem_addr] <= mem_write_data;
  end
  assign mem_read_data = mem[mem_addr];

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } acc_t;
  acc_t exp_q[$];

  typedef struct {
    logic [15:0]       src;
    logic [15:0]       dst;
    logic [7:0]        len;
    logic              poke;
    int                pre_n;
    logic [3:0][15:0]  pre;
    int                exp_done;
    int                exp_busy;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                              input logic p, input int ed, input int eb);
    vec_t v;
    v.src = s; v.dst = d; v.len = l; v.poke = p;
    v.pre_n = 0; v.pre = '0;
    v.exp_done = ed; v.exp_busy = eb;
    return v;
  endfunction

  task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
    refm[a] = d;
  endtask

  task automatic preload(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) bd_write(base + 16'(k), 16'($urandom));
  endtask

  // Reference: strict ascending word copy over the model memory, recording each access.
  task automatic build_expected(input logic [15:0] s, input logic [15:0] d, input int n);
    logic [15:0] w;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      w = refm[s + 16'(k)];
      exp_q.push_back('{wr: 1'b0, addr: s + 16'(k), data: w});
      refm[d + 16'(k)] = w;
      exp_q.push_back('{wr: 1'b1, addr: d + 16'(k), data: w});
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int   done_cyc;
    int   done_cnt;
    int   busy_cnt;
    acc_t e;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    preload(v.src, int'(v.len) + 1);
    preload(v.dst, int'(v.len) + 1);
    for (int k = 0; k < v.pre_n; k++) bd_write(v.src + 16'(k), v.pre[k]);
    build_expected(v.src, v.dst, int'(v.len));

    @(negedge clk);
    start = 1'b1; src_addr = v.src; dst_addr = v.dst; length = v.len;
    @(posedge clk);
    #1;
    start = 1'b0; src_addr = 16'($urandom); dst_addr = 16'($urandom); length = 8'($urandom);

    for (int c = 1; c <= v.exp_busy + 2; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = c; end
      chk("strobe_exclusive", 64'(mem_read & mem_write), 64'd0);
      if (mem_read || mem_write) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("access_kind", 64'(mem_write), 64'(e.wr));
          chk("access_addr", 64'(mem_addr), 64'(e.addr));
          if (e.wr) chk("write_data", 64'(mem_write_data), 64'(e.data));
        end else begin
          chk("extra_access", 64'(exp_q.size()), 64'd1);
        end
      end
      if (!busy) chk("idle_outputs", {mem_read, mem_write, done, mem_addr, mem_write_data}, 64'd0);
      if (v.poke && c == 2) begin
        start = 1'b1; src_addr = 16'($urandom); dst_addr = 16'($urandom); length = 8'($urandom);
      end
      if (v.poke && c == 3) start = 1'b0;
    end
    chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_cycles", 64'(busy_cnt), 64'(v.exp_busy));
    chk("missing_access", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k <= int'(v.len); k++)
      chk("mem_dst", 64'(mem[v.dst + 16'(k)]), 64'(refm[v.dst + 16'(k)]));
  endtask

  initial begin
    logic [15:0] w0, w1, u2, u3, hv;
    vec_t rv;

    rst_n = 1'b0; start = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    src_addr = '0; dst_addr = '0; length = '0;

    vecs[0] = mk(16'h0010, 16'h0040, 8'd4, 1'b0, 9, 9);
    vecs[0].pre_n = 4;
    vecs[0].pre[0] = 16'hA1A1; vecs[0].pre[1] = 16'hB2B2;
    vecs[0].pre[2] = 16'hC3C3; vecs[0].pre[3] = 16'hD4D4;
    vecs[1] = mk(16'h0010, 16'h0020, 8'd0, 1'b0, 1, 1);
    vecs[2] = mk(16'hFFFE, 16'h0050, 8'd3, 1'b0, 7, 7);
    vecs[3] = mk(16'h0020, 16'h0021, 8'd3, 1'b0, 7, 7);
    vecs[3].pre_n = 1; vecs[3].pre[0] = 16'h1234;
    vecs[4] = mk(16'h0060, 16'h0080, 8'd5, 1'b1, 11, 11);
    for (int i = 5; i < NVEC; i++) begin
      rv = mk(16'($urandom), 16'($urandom), 8'($urandom_range(0, 12)), 1'($urandom), 0, 0);
      rv.exp_done = 2 * int'(rv.len) + 1;
      rv.exp_busy = 2 * int'(rv.len) + 1;
      if (rv.len == 8'd0) rv.poke = 1'b0;
      vecs[i] = rv;
    end

    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, mem_read, mem_write, mem_addr, mem_write_data}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_xfer(vecs[i]);

    // Start held high: re-accepted on the edge after DONE returns to IDLE.
    preload(16'h0300, 1);
    preload(16'h0310, 1);
    hv = refm[16'h0300];
    @(negedge clk);
    start = 1'b1; src_addr = 16'h0300; dst_addr = 16'h0310; length = 8'd1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) chk("held_done1", 64'(done), 64'd1);
      if (c == 4) chk("held_idle_gap", 64'(busy), 64'd0);
      if (c == 5) begin
        chk("held_reaccept_read", {mem_read, mem_addr}, {1'b1, 16'h0300});
        start = 1'b0;
      end
      if (c == 7) chk("held_done2", 64'(done), 64'd1);
      if (c == 8) chk("held_final_idle", 64'(busy), 64'd0);
    end
    refm[16'h0310] = hv;
    chk("held_mem", 64'(mem[16'h0310]), 64'(hv));

    // Reset after two words of a four-word copy.
    preload(16'h0100, 4);
    preload(16'h0200, 4);
    w0 = refm[16'h0100]; w1 = refm[16'h0101];
    u2 = refm[16'h0202]; u3 = refm[16'h0203];
    @(negedge clk);
    start = 1'b1; src_addr = 16'h0100; dst_addr = 16'h0200; length = 8'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_read", {mem_read, mem_addr}, {1'b1, 16'h0102});
    rst_n = 1'b0;
    #1;
    chk("async_reset_drop", {busy, done, mem_read, mem_write, mem_addr}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_done", {busy, done}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {busy, done}, 64'd0);
    chk("reset_word0", 64'(mem[16'h0200]), 64'(w0));
    chk("reset_word1", 64'(mem[16'h0201]), 64'(w1));
    chk("reset_word2_untouched", 64'(mem[16'h0202]), 64'(u2));
    chk("reset_word3_untouched", 64'(mem[16'h0203]), 64'(u3));
    refm[16'h0200] = w0; refm[16'h0201] = w1;

    run_xfer(mk(16'h0100, 16'h0200, 8'd4, 1'b0, 9, 9));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_data_mem_copier

`default_nettype wire

// File: doc/data_mem_copier.md
Name: data_mem_copier

Overview:
- Block-copy engine acting as the initiator side of the data-memory interface.
- Drives address, write data and the read/write strobes into the 16-bit data memory; consumes its combinational read data.
- Copies LENGTH words from a source base to a destination base. Used by the CPU datapath or test harness to move buffers without per-word software loads and stores.

Parameters:
- ADDR_W, 16, memory address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 16, memory word width.
- LEN_W, 8, width of the length field (max 2^LEN_W−1 words per transfer).

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- src_addr  input  ADDR_W  source base address; captured when start is accepted.
- dst_addr  input  ADDR_W  destination base address; captured when start is accepted.
- length  input  LEN_W  word count; captured when start is accepted.
- busy  output  1  high from accept until the DONE state is left.
- done  output  1  one-cycle completion pulse.
- mem_addr  output  ADDR_W  address to data memory.
- mem_write_data  output  DATA_W  write data to data memory.
- mem_read_data  input  DATA_W  combinational read data from data memory (valid in the same cycle as mem_read).
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe; memory commits on the posedge while high.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; captured registers and word index cleared.
  - busy=0, done=0, mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0.
- FSM states: IDLE, READ, WRITE, DONE. All outputs are Moore, decoded from state and registers.
- IDLE:
  - All strobes 0; mem_addr=0; mem_write_data=0.
  - On a posedge with start=1: capture src/dst/length and clear index i.
  - If length≠0, go to READ; if length=0, go to DONE.
- READ:
  - mem_read=1, mem_addr=src+i, mem_write=0.
  - On the next posedge, latch mem_read_data into the data buffer and go to WRITE.
- WRITE:
  - mem_write=1, mem_addr=dst+i, mem_write_data=buffer, mem_read=0.
  - On the next posedge, if i==length−1 go to DONE; otherwise i←i+1 and go to READ.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Strobe rule: mem_read and mem_write are never high in the same cycle.
- Throughput and latency:
  - 2 cycles per word.
  - Start accepted at edge E0 → done is high during the cycle following edge E0+2N.
  - length=0 → done is high in the cycle after E0, with no memory strobes.
- Boundary conditions:
  - start while busy: ignored; captured values are unchanged.
  - start held high: one transfer per IDLE visit. It is re-accepted on the edge after DONE returns to IDLE.
  - Address wrap: src+i and dst+i wrap modulo 2^ADDR_W (e.g. 0xFFFF+1 → 0x0000).
  - Overlapping regions: strict ascending word-by-word copy. Each read observes prior writes of the same transfer, so dst=src+1 replicates word src.
  - Reset mid-transfer: immediate return to IDLE with strobes low. Words already written remain in memory; no done pulse.
  - Input changes to src_addr/dst_addr/length during busy have no effect.

Decomposition:
- Shared package:
  - State encoding typedef (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3).
  - ADDR_W/DATA_W defaults, shared with the data memory.
- Sub-modules: none required; a single FSM plus datapath registers.
- The bench instantiates the existing 16-bit data memory as the responder.

Test Plan:
- Preload mem[0x10..0x13]=0xA1A1,0xB2B2,0xC3C3,0xD4D4; start with src=0x10, dst=0x40, len=4 → mem[0x40..0x43] equal the source values; done high exactly 1 cycle, 8 cycles after accept; busy high 9 cycles.
- len=0, src=0x10, dst=0x20 → done high the cycle after accept; mem_read and mem_write never asserted; memory unchanged.
- src=0xFFFE, dst=0x0050, len=3 (memory sized to cover addresses) → reads at 0xFFFE, 0xFFFF, 0x0000; writes at 0x50..0x52.
- Overlap: mem[0x20]=0x1234, src=0x20, dst=0x21, len=3 → mem[0x21..0x23] all 0x1234.
- Pulse start with new src/dst/len during a transfer → ignored; results match the original request only.
- Assert rst_n=0 after 2 words of a len=4 copy → strobes drop asynchronously, busy=0, no done; mem[dst+0..1] written, mem[dst+2..3] untouched; a new start after release completes normally.
